uart_receiver: RTL and testbench

- Receive-side engine for the PIC16F-compatible UART peripheral.
- Consumes the serial line (UART_RXD) and the oversampling strobe from the baud rate generator.
- Recovers 8N1 frames and buffers completed bytes in the 2-deep RCREG FIFO.
- Presents RXIF, FERR, OERR and the RCREG head byte to the uart register wrapper, which maps them onto RCSTA/RCREG.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_fifo.sv | 100 ++++++++++
 rtl/uart_receiver.sv | 186 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive/transmit types and constants
//
// Purpose: state encoding shared by the receiver and transmitter FSMs, the
// mid-bit sample positions used by the 16x oversampling majority vote, the
// RCSTA bit positions used by the register wrapper, and a 2-of-3 vote helper.
// Ports: none (package).

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rsr_state_t;

    localparam int DATA_BITS     = 8;

    // Sample positions within one bit period (16 ticks per bit).
    localparam int SAMPLE_MID_LO = 7;
    localparam int SAMPLE_MID    = 8;
    localparam int SAMPLE_MID_HI = 9;

    // RCSTA register bit positions.
    localparam int SPEN          = 7;
    localparam int CREN          = 4;
    localparam int FERR          = 2;
    localparam int OERR          = 1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - RCREG receive FIFO, FIFO_DEPTH entries of {ferr, data}
//
// Purpose: buffers completed receive frames. A pop and a push in the same
// cycle are both honoured (pop first), so a full FIFO can accept a push when
// it is being read on that cycle. When empty, the head output keeps showing
// the most recently popped entry.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_data   write strobe and {ferr, data[7:0]} entry
//   pop               read strobe; ignored when empty
//   flush             empties the FIFO; dominates push and pop
//   head_data         current head entry (or last popped entry when empty)
//   empty, full       occupancy flags

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS:0]   push_data,
    input  logic                 pop,
    input  logic                 flush,
    output logic [DATA_BITS:0]   head_data,
    output logic                 empty,
    output logic                 full
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_BITS:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_BITS:0] last_q, last_d;
    logic               do_pop, do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNT_FULL);
        do_pop    = pop & ~empty;
        // A full FIFO still takes the push when the head leaves on the same cycle.
        do_push   = push & (~full | do_pop);
        head_data = empty ? last_q : mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                last_d   = mem_q[rd_ptr_q];
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive engine with RCREG FIFO
//
// Purpose: synchronises UART_RXD, recovers 8N1 frames with a 3-sample
// mid-bit majority vote at OVERSAMPLE ticks per bit, and buffers bytes with
// their framing error flag in the RCREG FIFO.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   UART_RXD        serial line, idles high
//   sample_tick     OVERSAMPLE x baud strobe
//   spen, cren      serial port enable / continuous receive enable
//   rcreg_rd_en     pops the FIFO head
//   rcreg_out       FIFO head data
//   ferr_out        framing error flag of the head entry
//   oerr_out        sticky overrun flag
//   rxif_set_en     FIFO non-empty
//   rx_busy         frame reception in progress

module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 UART_RXD,
    input  logic                 sample_tick,
    input  logic                 spen,
    input  logic                 cren,
    input  logic                 rcreg_rd_en,
    output logic [DATA_BITS-1:0] rcreg_out,
    output logic                 ferr_out,
    output logic                 oerr_out,
    output logic                 rxif_set_en,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_LO    = CNT_W'(SAMPLE_MID_LO);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(SAMPLE_MID);
    localparam logic [CNT_W-1:0] CNT_HI    = CNT_W'(SAMPLE_MID_HI);
    localparam logic [2:0]       BIDX_LAST = 3'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rsr_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bidx_q, bidx_d;
    logic [DATA_BITS-1:0]   rsr_q, rsr_d;
    logic                   smp_lo_q, smp_lo_d;
    logic                   smp_mid_q, smp_mid_d;
    logic                   oerr_q, oerr_d;

    logic                   rxs;
    logic                   maj;
    logic                   rx_enable;
    logic                   push;
    logic [DATA_BITS:0]     push_data;
    logic [DATA_BITS:0]     head;
    logic                   fifo_empty;
    logic                   fifo_full;

    always_comb begin
        sync_d    = SYNC_STAGES'({sync_q, UART_RXD});
        rxs       = sync_q[SYNC_STAGES-1];
        // The third vote is the live sample at SAMPLE_MID_HI.
        maj       = majority3(smp_lo_q, smp_mid_q, rxs);
        rx_enable = spen & cren;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bidx_q    <= '0;
            rsr_q     <= '0;
            smp_lo_q  <= 1'b1;
            smp_mid_q <= 1'b1;
            oerr_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bidx_q    <= bidx_d;
            rsr_q     <= rsr_d;
            smp_lo_q  <= smp_lo_d;
            smp_mid_q <= smp_mid_d;
            oerr_q    <= oerr_d;
        end
    end

    // cnt_q holds the sample index of the tick about to be processed. The
    // tick that detects the start edge is sample 0, so START is entered with 1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bidx_d    = bidx_q;
        rsr_d     = rsr_q;
        smp_lo_d  = smp_lo_q;
        smp_mid_d = smp_mid_q;
        oerr_d    = oerr_q;
        if (!rx_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            bidx_d  = '0;
            rsr_d   = '0;
            oerr_d  = 1'b0;
        end else if (sample_tick) begin
            if (state_q != IDLE) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            if (cnt_q == CNT_LO) begin
                smp_lo_d = rxs;
            end
            if (cnt_q == CNT_MID) begin
                smp_mid_d = rxs;
            end
            case (state_q)
                IDLE: begin
                    if (!oerr_q && !rxs) begin
                        state_d = START;
                        cnt_d   = CNT_W'(1);
                    end
                end
                START: begin
                    if (cnt_q == CNT_HI && maj) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = DATA;
                        bidx_d  = '0;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_HI) begin
                        rsr_d[bidx_q] = maj;
                    end
                    if (cnt_q == CNT_LAST) begin
                        if (bidx_q == BIDX_LAST) begin
                            state_d = STOP;
                        end else begin
                            bidx_d = bidx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Decide at mid stop bit so a following start edge is not missed.
                    if (push) begin
                        state_d = IDLE;
                        if (fifo_full && !rcreg_rd_en) begin
                            oerr_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        push      = rx_enable & sample_tick & (state_q == STOP) & (cnt_q == CNT_HI);
        push_data = {~maj, rsr_q};
        rx_busy   = (state_q != IDLE);
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (rcreg_rd_en),
        .flush      (~spen),
        .head_data  (head),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign rcreg_out   = head[DATA_BITS-1:0];
    assign ferr_out    = head[DATA_BITS];
    assign oerr_out    = oerr_q;
    assign rxif_set_en = ~fifo_empty;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver

module tb_uart_receiver;

    localparam int DEPTH     = 2;
    localparam int PUSH_EDGE = 155;
    localparam int DET_EDGE  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       UART_RXD;
    logic       sample_tick;
    logic       spen;
    logic       cren;
    logic       rcreg_rd_en;
    logic [7:0] rcreg_out;
    logic       ferr_out;
    logic       oerr_out;
    logic       rxif_set_en;
    logic       rx_busy;

    uart_receiver #(
        .OVERSAMPLE  (16),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .UART_RXD    (UART_RXD),
        .sample_tick (sample_tick),
        .spen        (spen),
        .cren        (cren),
        .rcreg_rd_en (rcreg_rd_en),
        .rcreg_out   (rcreg_out),
        .ferr_out    (ferr_out),
        .oerr_out    (oerr_out),
        .rxif_set_en (rxif_set_en),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: frames in flight land in the FIFO PUSH_EDGE edges after their
    // first low capture unless aborted or refused while the overrun flag is set.
    typedef struct {
        int         start;
        logic [8:0] val;
    } frame_t;

    frame_t     pend[$];
    logic [8:0] mq[$];
    logic [8:0] m_last = '0;
    logic       m_oerr = 1'b0;
    int         cyc = 0;
    logic       mon_en = 1'b0;

    task automatic model_clear();
        pend.delete();
        mq.delete();
        m_last = '0;
        m_oerr = 1'b0;
    endtask

    always @(negedge rst) model_clear();

    always @(posedge clk) begin
        frame_t f;
        cyc++;
        if (!rst) begin
            model_clear();
        end else begin
            if (!spen) begin
                mq.delete();
            end else if (rcreg_rd_en && mq.size() > 0) begin
                m_last = mq.pop_front();
            end
            if (!spen || !cren) begin
                pend.delete();
                m_oerr = 1'b0;
            end else begin
                if (pend.size() > 0 && cyc == pend[0].start + DET_EDGE && m_oerr) begin
                    f = pend.pop_front();
                end
                if (pend.size() > 0 && cyc == pend[0].start + PUSH_EDGE) begin
                    f = pend.pop_front();
                    if (mq.size() < DEPTH) mq.push_back(f.val);
                    else m_oerr = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp_head;
        if (mon_en) begin
            exp_head = (mq.size() > 0) ? mq[0] : m_last;
            chk("mon_rxif", 32'(rxif_set_en), 32'(mq.size() > 0));
            chk("mon_oerr", 32'(oerr_out), 32'(m_oerr));
            chk("mon_rcreg", 32'(rcreg_out), 32'(exp_head[7:0]));
            chk("mon_ferr", 32'(ferr_out), 32'(exp_head[8]));
        end
    end

    // Called at a negedge; the next posedge is E0.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        frame_t     f;
        bits    = {stop_bit, d, 1'b0};
        f.start = cyc + 1;
        f.val   = {~stop_bit, d};
        pend.push_back(f);
        for (int i = 0; i < 10; i++) begin
            UART_RXD = bits[i];
            repeat (16) @(negedge clk);
        end
        UART_RXD = 1'b1;
    endtask

    task automatic do_pop();
        rcreg_rd_en = 1'b1;
        @(negedge clk);
        rcreg_rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; UART_RXD = 1'b1; sample_tick = 1'b1;
        spen = 1'b1; cren = 1'b1; rcreg_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rcreg", 32'(rcreg_out), 32'h0);
        chk("rst_ferr", 32'(ferr_out), 32'h0);
        chk("rst_oerr", 32'(oerr_out), 32'h0);
        chk("rst_rxif", 32'(rxif_set_en), 32'h0);
        chk("rst_busy", 32'(rx_busy), 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame, push exactly at E155.
        fork
            send_frame(8'hCA, 1'b1);
            begin
                repeat (155) @(negedge clk);
                chk("rxif_e154", 32'(rxif_set_en), 32'h0);
                @(negedge clk);
                chk("rxif_e155", 32'(rxif_set_en), 32'h1);
                chk("rcreg_ca", 32'(rcreg_out), 32'hCA);
                chk("ferr_ca", 32'(ferr_out), 32'h0);
                chk("oerr_ca", 32'(oerr_out), 32'h0);
            end
        join
        do_pop();
        chk("rxif_after_pop", 32'(rxif_set_en), 32'h0);
        chk("rcreg_hold", 32'(rcreg_out), 32'hCA);

        // False start: 5-cycle glitch.
        repeat (4) @(negedge clk);
        UART_RXD = 1'b0;
        repeat (5) @(negedge clk);
        UART_RXD = 1'b1;
        chk("busy_glitch", 32'(rx_busy), 32'h1);
        repeat (6) @(negedge clk);
        chk("busy_before_vote", 32'(rx_busy), 32'h1);
        @(negedge clk);
        chk("busy_false_exit", 32'(rx_busy), 32'h0);
        chk("rxif_false", 32'(rxif_set_en), 32'h0);
        repeat (4) @(negedge clk);

        // Framing error then a clean frame.
        send_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        chk("rcreg_55", 32'(rcreg_out), 32'h55);
        chk("ferr_55", 32'(ferr_out), 32'h1);
        do_pop();
        send_frame(8'h01, 1'b1);
        chk("rcreg_01", 32'(rcreg_out), 32'h01);
        chk("ferr_01", 32'(ferr_out), 32'h0);
        do_pop();
        repeat (4) @(negedge clk);

        // Overrun.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        chk("oerr_set", 32'(oerr_out), 32'h1);
        chk("rcreg_11", 32'(rcreg_out), 32'h11);
        send_frame(8'h77, 1'b1);
        chk("oerr_hold", 32'(oerr_out), 32'h1);
        chk("rcreg_11_kept", 32'(rcreg_out), 32'h11);
        do_pop();
        chk("rcreg_22", 32'(rcreg_out), 32'h22);
        do_pop();
        chk("rxif_ovr_empty", 32'(rxif_set_en), 32'h0);
        chk("rcreg_22_hold", 32'(rcreg_out), 32'h22);
        cren = 1'b0;
        @(negedge clk);
        cren = 1'b1;
        @(negedge clk);
        chk("oerr_cleared", 32'(oerr_out), 32'h0);
        repeat (4) @(negedge clk);

        // Simultaneous pop and push on a full FIFO.
        send_frame(8'hA1, 1'b1);
        send_frame(8'hB2, 1'b1);
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (155) @(negedge clk);
                rcreg_rd_en = 1'b1;
                @(negedge clk);
                rcreg_rd_en = 1'b0;
                chk("oerr_simul", 32'(oerr_out), 32'h0);
                chk("rcreg_b2", 32'(rcreg_out), 32'hB2);
                chk("rxif_simul", 32'(rxif_set_en), 32'h1);
            end
        join
        do_pop();
        chk("rcreg_44", 32'(rcreg_out), 32'h44);
        do_pop();
        chk("rxif_simul_empty", 32'(rxif_set_en), 32'h0);
        repeat (4) @(negedge clk);

        // Abort with spen=0 mid-DATA, one entry buffered.
        send_frame(8'h3C, 1'b1);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (60) @(negedge clk);
                chk("busy_mid_data", 32'(rx_busy), 32'h1);
                chk("rxif_before_abort", 32'(rxif_set_en), 32'h1);
                spen = 1'b0;
                @(negedge clk);
                chk("busy_abort", 32'(rx_busy), 32'h0);
                chk("rxif_abort", 32'(rxif_set_en), 32'h0);
            end
        join
        spen = 1'b1;
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-frame.
        send_frame(8'hE7, 1'b1);
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (80) @(negedge clk);
                #2 rst = 1'b0;
                #1;
                chk("arst_rcreg", 32'(rcreg_out), 32'h0);
                chk("arst_ferr", 32'(ferr_out), 32'h0);
                chk("arst_oerr", 32'(oerr_out), 32'h0);
                chk("arst_rxif", 32'(rxif_set_en), 32'h0);
                chk("arst_busy", 32'(rx_busy), 32'h0);
            end
        join
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h0F, 1'b1);
        chk("rcreg_0f", 32'(rcreg_out), 32'h0F);
        chk("rxif_0f", 32'(rxif_set_en), 32'h1);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
